ex_branch_resolve: RTL and testbench

Execute-stage branch/jump resolution unit for the 32-bit RISC-V pipeline. It sits directly downstream of the ID/EX register and feeds the fetch stage. Each cycle it evaluates rs1/rs2 with the signed/unsigned less-than comparison and equality for BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR, and computes the target. It then issues a registered redirect to fetch under a valid/ready handshake and generates the IF/ID and ID/EX flush pulses.

---
 rtl/ex_branch_resolve_if.sv | 72 +++++++
 rtl/ex_branch_resolve.sv | 161 ++++++++++++++++
 tb/tb_ex_branch_resolve.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_branch_resolve_if.sv
// ----------------------------------------------------------------------------
// ex_branch_resolve_if
// Bundles the ID/EX-side instruction slot and the fetch-side redirect channel
// of the execute-stage branch resolution unit.
//
// Signals:
//   in_valid/in_ready           instruction slot handshake
//   in_is_branch/jal/jalr       decoded class (one-hot or all zero)
//   in_funct3                   branch condition code
//   in_pc/in_imm/in_rs1/in_rs2  operands (imm already sign-extended)
//   redirect_valid/pc/ready     registered redirect request to fetch
//   flush                       kill IF/ID and ID/EX (redirect handshake fires)
//   link_pc                     pc+4 of the last accepted instruction
//   exc_misalign/exc_illegal    one-cycle exception pulses
//   stat_branches/stat_taken    branch counters (only with BRANCH_STATS_EN)
//
// Modports: slave = the resolution unit, master = the surrounding pipeline.
// Optional feature macro: BRANCH_STATS_EN.
// ----------------------------------------------------------------------------
interface ex_branch_resolve_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            in_is_branch;
    logic            in_is_jal;
    logic            in_is_jalr;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;
    logic            flush;
    logic [XLEN-1:0] link_pc;
    logic            exc_misalign;
    logic            exc_illegal;
`ifdef BRANCH_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_taken;

    modport slave (
        input  in_valid, in_is_branch, in_is_jal, in_is_jalr, in_funct3,
               in_pc, in_imm, in_rs1, in_rs2, redirect_ready,
        output in_ready, redirect_valid, redirect_pc, flush, link_pc,
               exc_misalign, exc_illegal, stat_branches, stat_taken
    );

    modport master (
        output in_valid, in_is_branch, in_is_jal, in_is_jalr, in_funct3,
               in_pc, in_imm, in_rs1, in_rs2, redirect_ready,
        input  in_ready, redirect_valid, redirect_pc, flush, link_pc,
               exc_misalign, exc_illegal, stat_branches, stat_taken
    );
`else
    modport slave (
        input  in_valid, in_is_branch, in_is_jal, in_is_jalr, in_funct3,
               in_pc, in_imm, in_rs1, in_rs2, redirect_ready,
        output in_ready, redirect_valid, redirect_pc, flush, link_pc,
               exc_misalign, exc_illegal
    );

    modport master (
        output in_valid, in_is_branch, in_is_jal, in_is_jalr, in_funct3,
               in_pc, in_imm, in_rs1, in_rs2, redirect_ready,
        input  in_ready, redirect_valid, redirect_pc, flush, link_pc,
               exc_misalign, exc_illegal
    );
`endif
endinterface

// File: rtl/ex_branch_resolve.sv
// ----------------------------------------------------------------------------
// ex_branch_resolve
// Execute-stage branch/jump resolution for the RV32 pipeline. Evaluates the
// branch condition, computes the target, and issues a registered redirect to
// fetch under a valid/ready handshake. flush fires in the cycle the redirect
// is taken by fetch.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   ex_branch_resolve_if.slave (instruction slot, redirect channel,
//         link pc, exception pulses, optional counters)
//
// Optional feature macro: BRANCH_STATS_EN adds stat_branches/stat_taken,
// counting accepted conditional branches and those whose condition held.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no redirect outstanding, accepting instructions
// PEND  | redirect_valid=1, holding redirect_pc until redirect_ready
// ----------------------------------------------------------------------------
module ex_branch_resolve #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    ex_branch_resolve_if.slave bus
);
    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    state_t          state_q, state_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] link_pc_q, link_pc_d;
    logic            exc_misalign_q, exc_misalign_d;
    logic            exc_illegal_q, exc_illegal_d;

    logic            accept;
    logic            eq, lt, ltu, low_lt;
    logic            cond, f3_illegal;
    logic            taken, misaligned;
    logic [XLEN-1:0] target;

    assign accept = bus.in_valid & (state_q == IDLE);

    // With matching sign bits both compares reduce to the magnitude of the
    // low bits; with differing sign bits the sign alone decides.
    assign low_lt = bus.in_rs1[XLEN-2:0] < bus.in_rs2[XLEN-2:0];

    always_comb begin
        eq  = (bus.in_rs1 == bus.in_rs2);
        lt  = low_lt;
        ltu = low_lt;
        if (bus.in_rs1[XLEN-1] != bus.in_rs2[XLEN-1]) begin
            lt  = bus.in_rs1[XLEN-1];
            ltu = bus.in_rs2[XLEN-1];
        end
    end

    always_comb begin
        cond       = 1'b0;
        f3_illegal = 1'b0;
        case (bus.in_funct3)
            3'b000:  cond = eq;
            3'b001:  cond = ~eq;
            3'b100:  cond = lt;
            3'b101:  cond = ~lt;
            3'b110:  cond = ltu;
            3'b111:  cond = ~ltu;
            default: f3_illegal = 1'b1;
        endcase
    end

    always_comb begin
        target = bus.in_pc + bus.in_imm;
        if (bus.in_is_jalr) begin
            target = (bus.in_rs1 + bus.in_imm) & JALR_MASK;
        end
        taken      = bus.in_is_jal | bus.in_is_jalr | (bus.in_is_branch & cond);
        misaligned = (target[1:0] != 2'b00);
    end

    always_comb begin
        state_d        = state_q;
        redirect_pc_d  = redirect_pc_q;
        link_pc_d      = link_pc_q;
        exc_misalign_d = 1'b0;
        exc_illegal_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    link_pc_d     = bus.in_pc + XLEN'(4);
                    exc_illegal_d = bus.in_is_branch & f3_illegal;
                    if (taken) begin
                        if (misaligned) begin
                            exc_misalign_d = 1'b1;
                        end else begin
                            state_d       = PEND;
                            redirect_pc_d = target;
                        end
                    end
                end
            end
            PEND: begin
                if (bus.redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            redirect_pc_q  <= '0;
            link_pc_q      <= '0;
            exc_misalign_q <= 1'b0;
            exc_illegal_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            redirect_pc_q  <= redirect_pc_d;
            link_pc_q      <= link_pc_d;
            exc_misalign_q <= exc_misalign_d;
            exc_illegal_q  <= exc_illegal_d;
        end
    end

    assign bus.in_ready       = (state_q == IDLE);
    assign bus.redirect_valid = (state_q == PEND);
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = (state_q == PEND) & bus.redirect_ready;
    assign bus.link_pc        = link_pc_q;
    assign bus.exc_misalign   = exc_misalign_q;
    assign bus.exc_illegal    = exc_illegal_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_taken_q;

    // Illegal funct3 counts as a branch but never as taken (cond stays 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q <= '0;
            stat_taken_q    <= '0;
        end else if (accept & bus.in_is_branch) begin
            stat_branches_q <= stat_branches_q + 32'd1;
            if (cond) begin
                stat_taken_q <= stat_taken_q + 32'd1;
            end
        end
    end

    assign bus.stat_branches = stat_branches_q;
    assign bus.stat_taken    = stat_taken_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif
endmodule

// File: tb/tb_ex_branch_resolve.sv
// ----------------------------------------------------------------------------
// tb_ex_branch_resolve
// Directed cases with literal expectations followed by randomized traffic.
// A behavioural model tracks the expected outputs and a negedge process
// compares every output against it each cycle.
// ----------------------------------------------------------------------------
module tb_ex_branch_resolve;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ex_branch_resolve_if #(.XLEN(32)) bus ();

    ex_branch_resolve #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_rv   = 1'b0;
    logic [31:0] m_pc   = '0;
    logic [31:0] m_link = '0;
    logic        m_mis  = 1'b0;
    logic        m_ill  = 1'b0;
    logic [31:0] m_br   = '0;
    logic [31:0] m_tk   = '0;

    function automatic logic cond_holds(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        logic        acc, tk;
        logic [31:0] tgt;
        if (rst) begin
            m_rv = 0; m_pc = 0; m_link = 0; m_mis = 0; m_ill = 0; m_br = 0; m_tk = 0;
        end else begin
            acc   = bus.in_valid && !m_rv;
            m_mis = 0;
            m_ill = 0;
            if (acc) begin
                if (bus.in_is_jalr) tgt = (bus.in_rs1 + bus.in_imm) & 32'hFFFF_FFFE;
                else                tgt = bus.in_pc + bus.in_imm;
                tk = bus.in_is_jal || bus.in_is_jalr ||
                     (bus.in_is_branch && cond_holds(bus.in_funct3, bus.in_rs1, bus.in_rs2));
                m_link = bus.in_pc + 32'd4;
                m_ill  = bus.in_is_branch && (bus.in_funct3 == 3'd2 || bus.in_funct3 == 3'd3);
                if (bus.in_is_branch) begin
                    m_br = m_br + 1;
                    if (tk) m_tk = m_tk + 1;
                end
                if (tk) begin
                    if (tgt % 4 != 0) m_mis = 1;
                    else begin
                        m_rv = 1;
                        m_pc = tgt;
                    end
                end
            end else if (m_rv && bus.redirect_ready) begin
                m_rv = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_in_ready",   32'(bus.in_ready),       32'(!m_rv));
        chk("m_rvalid",     32'(bus.redirect_valid), 32'(m_rv));
        chk("m_rpc",        bus.redirect_pc,         m_pc);
        chk("m_flush",      32'(bus.flush),          32'(m_rv && bus.redirect_ready));
        chk("m_link",       bus.link_pc,             m_link);
        chk("m_misalign",   32'(bus.exc_misalign),   32'(m_mis));
        chk("m_illegal",    32'(bus.exc_illegal),    32'(m_ill));
`ifdef BRANCH_STATS_EN
        chk("m_stat_br",    bus.stat_branches,       m_br);
        chk("m_stat_tk",    bus.stat_taken,          m_tk);
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_valid     = 1'b1;
        bus.in_is_branch = br;
        bus.in_is_jal    = jal;
        bus.in_is_jalr   = jalr;
        bus.in_funct3    = f3;
        bus.in_pc        = pc;
        bus.in_imm       = imm;
        bus.in_rs1       = rs1;
        bus.in_rs2       = rs2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_one(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                             input logic [31:0] pc, input logic [31:0] imm,
                             input logic [31:0] rs1, input logic [31:0] rs2);
        drive(br, jal, jalr, f3, pc, imm, rs1, rs2);
        step();
        bus.in_valid = 1'b0;
        step();
    endtask

    initial begin
        int cls, mode;
        bus.in_valid = 0; bus.in_is_branch = 0; bus.in_is_jal = 0; bus.in_is_jalr = 0;
        bus.in_funct3 = 0; bus.in_pc = 0; bus.in_imm = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
        bus.redirect_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", 32'(bus.redirect_valid), 32'd0);
        chk("rst_rpc",    bus.redirect_pc,         32'd0);
        chk("rst_link",   bus.link_pc,             32'd0);
        chk("rst_ready",  32'(bus.in_ready),       32'd1);
        chk("rst_flush",  32'(bus.flush),          32'd0);
        rst = 1'b0;
        step();

        // BEQ taken, fetch ready immediately
        drive(1, 0, 0, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5);
        step();
        bus.in_valid = 0;
        chk("beq_rvalid", 32'(bus.redirect_valid), 32'd1);
        chk("beq_rpc",    bus.redirect_pc,         32'h120);
        chk("beq_flush",  32'(bus.flush),          32'd1);
        chk("beq_link",   bus.link_pc,             32'h104);
        chk("beq_inrdy",  32'(bus.in_ready),       32'd0);
        step();
        chk("beq_idle",   32'(bus.redirect_valid), 32'd0);

        // BLT -1 < 1 taken; BLTU same operands not taken
        drive(1, 0, 0, 3'd4, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
        step();
        bus.in_valid = 0;
        chk("blt_rvalid", 32'(bus.redirect_valid), 32'd1);
        chk("blt_rpc",    bus.redirect_pc,         32'h240);
        step();
        drive(1, 0, 0, 3'd6, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
        step();
        bus.in_valid = 0;
        chk("bltu_rvalid", 32'(bus.redirect_valid), 32'd0);
        chk("bltu_link",   bus.link_pc,             32'h204);

        // JALR aligned and misaligned
        drive(0, 0, 1, 3'd0, 32'h40, 32'd3, 32'h1001, 32'd0);
        step();
        bus.in_valid = 0;
        chk("jalr_rvalid", 32'(bus.redirect_valid), 32'd1);
        chk("jalr_rpc",    bus.redirect_pc,         32'h1004);
        chk("jalr_link",   bus.link_pc,             32'h44);
        step();
        drive(0, 0, 1, 3'd0, 32'h40, 32'd5, 32'h1001, 32'd0);
        step();
        bus.in_valid = 0;
        chk("jalr_mis_rvalid", 32'(bus.redirect_valid), 32'd0);
        chk("jalr_mis_exc",    32'(bus.exc_misalign),   32'd1);
        step();
        chk("jalr_mis_clear",  32'(bus.exc_misalign),   32'd0);

        // fetch stalls three cycles, then accepts
        bus.redirect_ready = 1'b0;
        drive(1, 0, 0, 3'd1, 32'h300, 32'h10, 32'd1, 32'd2);
        step();
        bus.in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_rvalid", 32'(bus.redirect_valid), 32'd1);
            chk("stall_rpc",    bus.redirect_pc,         32'h310);
            chk("stall_inrdy",  32'(bus.in_ready),       32'd0);
            chk("stall_flush",  32'(bus.flush),          32'd0);
            step();
        end
        bus.redirect_ready = 1'b1;
        #1;
        chk("stall_flush4", 32'(bus.flush), 32'd1);
        step();
        chk("stall_done_rvalid", 32'(bus.redirect_valid), 32'd0);
        chk("stall_done_flush",  32'(bus.flush),          32'd0);

        // asynchronous reset in PEND
        bus.redirect_ready = 1'b0;
        drive(0, 1, 0, 3'd0, 32'h500, 32'h100, 32'd0, 32'd0);
        step();
        bus.in_valid = 0;
        chk("pend_rvalid", 32'(bus.redirect_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_rvalid", 32'(bus.redirect_valid), 32'd0);
        chk("arst_rpc",    bus.redirect_pc,         32'd0);
        chk("arst_link",   bus.link_pc,             32'd0);
        chk("arst_inrdy",  32'(bus.in_ready),       32'd1);
        rst = 1'b0;
        bus.redirect_ready = 1'b1;
        step();
        drive(1, 0, 0, 3'd5, 32'h10, 32'h8, 32'd3, 32'd3);
        step();
        bus.in_valid = 0;
        chk("post_rst_rvalid", 32'(bus.redirect_valid), 32'd1);
        chk("post_rst_rpc",    bus.redirect_pc,         32'h18);
        chk("post_rst_flush",  32'(bus.flush),          32'd1);
        step();

        // illegal funct3
        drive(1, 0, 0, 3'd2, 32'h80, 32'h8, 32'd7, 32'd7);
        step();
        bus.in_valid = 0;
        chk("ill_exc",    32'(bus.exc_illegal),    32'd1);
        chk("ill_rvalid", 32'(bus.redirect_valid), 32'd0);
        step();
        chk("ill_clear",  32'(bus.exc_illegal),    32'd0);

`ifdef BRANCH_STATS_EN
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        issue_one(1, 0, 0, 3'd0, 32'h0, 32'h8, 32'd1, 32'd1);
        issue_one(1, 0, 0, 3'd1, 32'h0, 32'h8, 32'd1, 32'd1);
        issue_one(1, 0, 0, 3'd3, 32'h0, 32'h8, 32'd1, 32'd2);
        issue_one(1, 0, 0, 3'd6, 32'h0, 32'h8, 32'd1, 32'd2);
        issue_one(0, 1, 0, 3'd0, 32'h0, 32'h8, 32'd0, 32'd0);
        chk("stat_branches", bus.stat_branches, 32'd4);
        chk("stat_taken",    bus.stat_taken,    32'd2);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            bus.redirect_ready = ($urandom_range(0, 2) != 0);
            bus.in_valid       = ($urandom_range(0, 3) != 0);
            cls = $urandom_range(0, 5);
            bus.in_is_branch = (cls <= 2);
            bus.in_is_jal    = (cls == 3);
            bus.in_is_jalr   = (cls == 4);
            bus.in_funct3    = 3'($urandom_range(0, 7));
            bus.in_pc        = $urandom & 32'hFFFF_FFFC;
            bus.in_imm       = ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFE)
                                                           : (32'($urandom_range(0, 64)) - 32'd32) & 32'hFFFF_FFFE;
            if (cls == 4) bus.in_imm = $urandom;
            mode = $urandom_range(0, 3);
            bus.in_rs1 = $urandom;
            case (mode)
                0:       bus.in_rs2 = bus.in_rs1;
                1:       bus.in_rs2 = $urandom;
                2:       begin bus.in_rs1 = 32'($urandom_range(0, 4)) - 32'd2;
                               bus.in_rs2 = 32'($urandom_range(0, 4)) - 32'd2; end
                default: bus.in_rs2 = {~bus.in_rs1[31], 31'($urandom)};
            endcase
        end
        bus.in_valid = 0;
        bus.redirect_ready = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
